// File: rtl/stepdir_pkg.sv
// rtl/stepdir_pkg.sv - shared FSM encoding and default driver timing for the step path
package stepdir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } step_state_t;

    localparam int DEFAULT_SETUP_CYCLES = 20;
    localparam int DEFAULT_PULSE_CYCLES = 40;
    localparam int DEFAULT_GAP_CYCLES   = 40;
    localparam int DEFAULT_PENDING_BITS = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/step_dir_fifo.sv
// rtl/step_dir_fifo.sv - 1-bit direction FIFO with asynchronous reset
module step_dir_fifo #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 push_data,
    input  logic                 pop,
    output logic                 head,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

    logic [DEPTH-1:0]     mem_q, mem_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // A push into a full buffer only lands when a pop frees a slot on the same edge
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + ADDR_BITS'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (ADDR_BITS + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (ADDR_BITS + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/step_conditioner.sv
// rtl/step_conditioner.sv - buffers step/dir events and enforces driver setup, pulse and gap timing
module step_conditioner
    import stepdir_pkg::*;
#(
    parameter int SETUP_CYCLES = DEFAULT_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES,
    parameter int PENDING_BITS = DEFAULT_PENDING_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_in,
    input  logic                  dir_in,
    input  logic                  dedge,
    input  logic                  enable,
    output logic                  step_out,
    output logic                  dir_out,
    output logic [PENDING_BITS:0] pending,
    output logic                  busy,
    output logic                  overflow
);
    localparam int TW = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    step_state_t       state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              step_in_q;
    logic              step_out_q, step_out_d;
    logic              dir_out_q, dir_out_d;
    logic              mode_q, mode_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;
    logic              fifo_head, fifo_full, fifo_empty;
    logic [PENDING_BITS:0] fifo_count;
    logic              timer_done, do_dispatch, start_pulse, pulse_dedge;

    assign push = step_in && !step_in_q;

    step_dir_fifo #(
        .ADDR_BITS (PENDING_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (dir_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        step_out_d  = step_out_q;
        dir_out_d   = dir_out_q;
        mode_d      = mode_q;
        start_pulse = 1'b0;
        pulse_dedge = mode_q;
        timer_done  = (timer_q == '0);
        do_dispatch = enable && !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_GAP) && timer_done));
        pop         = do_dispatch;

        if ((state_q != ST_IDLE) && !timer_done) begin
            timer_d = timer_q - TW'(1);
        end
        if ((state_q == ST_SETUP) && timer_done) begin
            start_pulse = 1'b1;
        end
        if ((state_q == ST_PULSE) && timer_done) begin
            if (!mode_q) begin
                step_out_d = 1'b0;
            end
            state_d = ST_GAP;
            timer_d = GAP_LOAD;
        end
        if ((state_q == ST_GAP) && timer_done && !do_dispatch) begin
            state_d = ST_IDLE;
        end

        if (do_dispatch) begin
            mode_d      = dedge;
            pulse_dedge = dedge;
            if (fifo_head != dir_out_q) begin
                dir_out_d = fifo_head;
                state_d   = ST_SETUP;
                timer_d   = SETUP_LOAD;
                if (!dedge) begin
                    step_out_d = 1'b0;
                end
            end else if (!dedge && step_out_q) begin
                // Leaving dual-edge with the pin high: one low cycle so the pulse has a real rising edge
                step_out_d = 1'b0;
                state_d    = ST_SETUP;
                timer_d    = '0;
            end else begin
                start_pulse = 1'b1;
            end
        end

        if (start_pulse) begin
            state_d    = ST_PULSE;
            timer_d    = PULSE_LOAD;
            step_out_d = pulse_dedge ? !step_out_q : 1'b1;
        end

        overflow_d = overflow_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            step_in_q  <= 1'b0;
            step_out_q <= 1'b0;
            dir_out_q  <= 1'b0;
            mode_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            step_in_q  <= step_in;
            step_out_q <= step_out_d;
            dir_out_q  <= dir_out_d;
            mode_q     <= mode_d;
            overflow_q <= overflow_d;
        end
    end

    assign step_out = step_out_q;
    assign dir_out  = dir_out_q;
    assign pending  = fifo_count;
    assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_step_conditioner.sv
// tb/tb_step_conditioner.sv - scoreboard bench for step_conditioner with small timing parameters
module tb_step_conditioner;
    localparam int SETUP = 4;
    localparam int PULSE = 3;
    localparam int GAP   = 2;
    localparam int PB    = 2;

    logic clk = 1'b0;
    logic reset, step_in, dir_in, dedge, enable;
    logic step_out, dir_out, busy, overflow;
    logic [PB:0] pending;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit exp_q[$];
    int edge_times[$];
    bit sb_dedge = 1'b0;
    logic prev_step = 1'b0;
    bit exp_bit;

    step_conditioner #(
        .SETUP_CYCLES (SETUP),
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP),
        .PENDING_BITS (PB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .step_in  (step_in),
        .dir_in   (dir_in),
        .dedge    (dedge),
        .enable   (enable),
        .step_out (step_out),
        .dir_out  (dir_out),
        .pending  (pending),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Each dispatched step (rise in normal mode, any toggle in dual-edge mode) pops the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            prev_step = 1'b0;
        end else begin
            if ((step_out !== prev_step) && (sb_dedge || (step_out === 1'b1))) begin
                edge_times.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected_step: step event at cycle %0d, expected no step", cyc);
                end else begin
                    exp_bit = exp_q.pop_front();
                    if (dir_out !== exp_bit)
                        $display("FAIL sb_dir: dir_out=%0b want %0b at cycle %0d", dir_out, exp_bit, cyc);
                    else
                        passes++;
                end
            end
            prev_step = step_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_step(input bit d, input bit expect_dispatch);
        dir_in  = d;
        step_in = 1'b1;
        if (expect_dispatch) exp_q.push_back(d);
        tick();
        step_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy !== 1'b0) && (n < 200)) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL %s_idle_timeout: busy=%0b want 0 after %0d cycles", tag, busy, n);
        else passes++;
    endtask

    task automatic run_single_step(input string tag);
        logic [7:0] s_hist, b_hist, d_hist;
        drive_step(1'b0, 1'b1);
        s_hist[0] = step_out;
        b_hist[0] = busy;
        d_hist[0] = dir_out;
        for (int k = 1; k < 8; k++) begin
            tick();
            s_hist[k] = step_out;
            b_hist[k] = busy;
            d_hist[k] = dir_out;
        end
        checks++;
        if (s_hist !== 8'b0000_1110) $display("FAIL %s_step_wave: got %b want %b", tag, s_hist, 8'b0000_1110);
        else passes++;
        checks++;
        if (b_hist !== 8'b0011_1111) $display("FAIL %s_busy_wave: got %b want %b", tag, b_hist, 8'b0011_1111);
        else passes++;
        checks++;
        if (d_hist !== 8'b0000_0000) $display("FAIL %s_dir_wave: got %b want %b", tag, d_hist, 8'b0000_0000);
        else passes++;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        step_in = 1'b0;
        dir_in  = 1'b0;
        dedge   = 1'b0;
        enable  = 1'b1;
        #2;
        checks++; if (step_out !== 1'b0) $display("FAIL reset_step_out: got %0b want 0", step_out); else passes++;
        checks++; if (dir_out !== 1'b0) $display("FAIL reset_dir_out: got %0b want 0", dir_out); else passes++;
        checks++; if (pending !== '0) $display("FAIL reset_pending: got %0d want 0", pending); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", overflow); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passes++;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        run_single_step("single");
        wait_idle("single");
    endtask

    task automatic test_dir_change();
        logic [9:0] s_hist, d_hist;
        drive_step(1'b1, 1'b1);
        s_hist[0] = step_out;
        d_hist[0] = dir_out;
        for (int k = 1; k < 10; k++) begin
            tick();
            s_hist[k] = step_out;
            d_hist[k] = dir_out;
        end
        checks++;
        if (s_hist !== 10'b00_1110_0000) $display("FAIL dirchg_step_wave: got %b want %b", s_hist, 10'b00_1110_0000);
        else passes++;
        checks++;
        if (d_hist !== 10'b11_1111_1110) $display("FAIL dirchg_dir_wave: got %b want %b", d_hist, 10'b11_1111_1110);
        else passes++;
        wait_idle("dirchg");
    endtask

    task automatic test_overflow();
        int n0, peak, bad;
        n0   = edge_times.size();
        peak = 0;
        for (int i = 0; i < 8; i++) begin
            drive_step(1'b1, i < 7);
            if (int'(pending) > peak) peak = int'(pending);
            if (i == 6) begin
                checks++;
                if (overflow !== 1'b0) $display("FAIL ovf_early: overflow=%0b want 0", overflow);
                else passes++;
            end
            if (i == 7) begin
                checks++;
                if (overflow !== 1'b1) $display("FAIL ovf_set: overflow=%0b want 1", overflow);
                else passes++;
            end
            tick();
            if (int'(pending) > peak) peak = int'(pending);
        end
        wait_idle("ovf");
        checks++;
        if (peak != 4) $display("FAIL ovf_peak: pending peak=%0d want 4", peak); else passes++;
        checks++;
        if (edge_times.size() - n0 != 7) $display("FAIL ovf_pulses: got %0d want 7", edge_times.size() - n0);
        else passes++;
        bad = 0;
        for (int i = n0 + 1; i < edge_times.size(); i++)
            if (edge_times[i] - edge_times[i-1] != PULSE + GAP) bad++;
        checks++;
        if (bad != 0) $display("FAIL ovf_spacing: %0d gaps differ from %0d", bad, PULSE + GAP); else passes++;
        checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky: overflow=%0b want 1", overflow); else passes++;
    endtask

    task automatic test_dual_edge();
        int n0, bad;
        dedge    = 1'b1;
        sb_dedge = 1'b1;
        n0 = edge_times.size();
        for (int i = 0; i < 3; i++) begin
            drive_step(1'b1, 1'b1);
            tick();
        end
        wait_idle("dedge");
        checks++;
        if (edge_times.size() - n0 != 3) $display("FAIL dedge_toggles: got %0d want 3", edge_times.size() - n0);
        else passes++;
        bad = 0;
        for (int i = n0 + 1; i < edge_times.size(); i++)
            if (edge_times[i] - edge_times[i-1] != PULSE + GAP) bad++;
        checks++;
        if (bad != 0) $display("FAIL dedge_spacing: %0d gaps differ from %0d", bad, PULSE + GAP); else passes++;
        checks++;
        if (step_out !== 1'b1) $display("FAIL dedge_final: step_out=%0b want 1", step_out); else passes++;
    endtask

    task automatic test_dedge_exit();
        logic [5:0] s_hist;
        dedge    = 1'b0;
        sb_dedge = 1'b0;
        drive_step(1'b1, 1'b1);
        s_hist[0] = step_out;
        for (int k = 1; k < 6; k++) begin
            tick();
            s_hist[k] = step_out;
        end
        checks++;
        if (s_hist !== 6'b01_1101) $display("FAIL dedge_exit_wave: got %b want %b", s_hist, 6'b01_1101);
        else passes++;
        wait_idle("dedge_exit");
    endtask

    task automatic test_enable();
        int n0, active;
        enable = 1'b0;
        tick();
        drive_step(1'b1, 1'b1);
        tick();
        drive_step(1'b1, 1'b1);
        active = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (step_out !== 1'b0) active++;
        end
        checks++;
        if (pending !== 3'd2) $display("FAIL en_pending: got %0d want 2", pending); else passes++;
        checks++;
        if (active != 0) $display("FAIL en_quiet: step_out active %0d cycles want 0", active); else passes++;
        checks++;
        if (busy !== 1'b1) $display("FAIL en_busy: got %0b want 1", busy); else passes++;
        n0 = edge_times.size();
        enable = 1'b1;
        tick();
        checks++;
        if (step_out !== 1'b1) $display("FAIL en_first: step_out=%0b want 1", step_out); else passes++;
        wait_idle("en");
        checks++;
        if ((edge_times.size() - n0 != 2) || (edge_times[edge_times.size()-1] - edge_times[n0] != PULSE + GAP))
            $display("FAIL en_second: %0d pulses, spacing wrong (want 2 pulses %0d apart)", edge_times.size() - n0, PULSE + GAP);
        else passes++;
    endtask

    task automatic test_async_reset();
        drive_step(1'b0, 1'b1);
        wait_idle("arst_pre");
        enable = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_step(1'b1, 1'b1);
            tick();
        end
        enable = 1'b1;
        tick();
        tick();
        checks++;
        if ((dir_out !== 1'b1) || (pending !== 3'd3))
            $display("FAIL arst_setup_state: dir_out=%0b pending=%0d want 1 and 3", dir_out, pending);
        else passes++;
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        checks++; if (step_out !== 1'b0) $display("FAIL arst_step_out: got %0b want 0", step_out); else passes++;
        checks++; if (dir_out !== 1'b0) $display("FAIL arst_dir_out: got %0b want 0", dir_out); else passes++;
        checks++; if (pending !== '0) $display("FAIL arst_pending: got %0d want 0", pending); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL arst_overflow: got %0b want 0", overflow); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %0b want 0", busy); else passes++;
        tick();
        tick();
        reset = 1'b0;
        tick();
        run_single_step("arst_single");
        wait_idle("arst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_dir_change();
        test_overflow();
        test_dual_edge();
        test_dedge_exit();
        test_enable();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d steps never dispatched, want 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
